ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester access controller for the 16 x 8 synchronous single-port RAM. It zero-fills the RAM after reset or on demand, then shares the RAM's single port between requesters A and B. Each cycle it grants at most one request and issues it to the RAM through a registered command stage. Read data is routed back to the requester that issued the read. The block sits between the RAM instance and its two client blocks.

## Interface

- AW, 4, address width; RAM depth is DEPTH = 2**AW
- DW, 8, data width
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  one-cycle pulse: restart zero-fill of the whole RAM
- init_done  out  1  high when zero-fill is complete and grants are possible
- a_req, b_req  in  1  request valid; held until the matching gnt
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  AW  request address
- a_wdata, b_wdata  in  DW  write data
- a_gnt, b_gnt  out  1  combinational grant; request accepted this cycle
- a_rvalid, b_rvalid  out  1  one-cycle pulse; read data valid
- a_rdata, b_rdata  out  DW  read data, qualified by rvalid
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  AW  RAM address (registered)
- ram_din  out  DW  RAM write data (registered)
- ram_dout  in  DW  RAM registered read data; updated only on non-write cycles

## Operation

- States: INIT and RUN. Reset enters INIT with clear counter = 0.
- INIT, each edge:
  - Load command register with we=1, addr=cnt, din=0; cnt++.
  - The edge that loads addr DEPTH-1 sets state=RUN and init_done=1.
- In INIT, and in any cycle where clr=1, both gnt outputs are 0.
- clr in RUN: next edge sets INIT, cnt=0, init_done=0.
- clr in INIT: restarts cnt at 0.
- RUN arbitration is combinational in the cycle of the request:
  - Only one requester asserts req: it is granted.
  - Both assert req: grant the requester not granted last (round-robin pointer).
  - The pointer updates only on a grant; its reset value makes A win the first tie.
- Grant edge: command register loads we/addr/wdata of the granted requester; a tag register loads {requester id, is_read}.
- Requester not granted keeps req and its fields stable; they are re-arbitrated next cycle.
- No request in RUN: ram_we=0, ram_addr/ram_din hold their last value. The resulting RAM read is ignored.
- Read return: one cycle after the command cycle, the tag stage asserts the owning rvalid; rdata = ram_dout.
- a_rdata and b_rdata may both mirror ram_dout; only rvalid qualifies them.
- In-flight reads complete normally across clr. A tag is never dropped.
- Throughput: one access per cycle, back-to-back, any mix of ports.

## Timing

- Reset values: init_done=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, ram_we=0, ram_addr=0, ram_din=0, pointer=favor A, cnt=0, tags invalid.
- Zero-fill: first write issued on the first edge after rst_n rises. init_done rises on the DEPTH-th edge, i.e. 16 cycles.
- Cycle N: gnt. Cycle N+1: command on RAM ports; RAM acts at the end of N+1. Cycle N+2: rvalid with data.
- Read latency: 2 cycles from grant.
- Write then read of the same address, granted on consecutive cycles: the read returns the new data. No hazard logic is needed.
- Reset mid-operation clears the pipeline, tags and pointer immediately, and restarts zero-fill.

## Configuration

- RAM_ARB_FIXED_PRI_EN defined: fixed priority, A always wins ties; the pointer is not implemented.
- RAM_ARB_FIXED_PRI_EN undefined (default): round-robin as above.

## Test plan

- Reset release, no requests -> 16 writes of 0x00 to addresses 0..15 in order; init_done high after 16 edges; then read addr 9 returns 0x00.
- A writes 0xA5 to addr 3, next cycle B reads addr 3 -> b_rvalid pulses 2 cycles after b_gnt with b_rdata=0xA5; a_rvalid stays 0.
- A and B both request reads continuously -> grants alternate A, B, A, B. Each rvalid arrives at its owner 2 cycles after its grant. With RAM_ARB_FIXED_PRI_EN defined, B is never granted while A requests.
- B read of addr 7 granted, clr pulsed the next cycle -> b_rvalid still delivered with pre-clear data. Then 16 zero writes occur; gnt=0 until init_done rises; a later read of addr 7 returns 0x00.
- rst_n asserted while reads are in flight -> rvalid and gnt drop immediately, with no stale rvalid after release. Zero-fill restarts from addr 0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of ram_port_arbiter: two request/grant/read-return
// channels (A and B). The requesters drive through the master modport, the
// arbiter sits on the slave modport.
interface ram_port_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: zero-fills a 2**AW x DW single-port synchronous RAM after
// reset or on clr, then shares its port between requesters A and B.
// Grants are combinational; the RAM command is registered; read data returns
// to its owner two cycles after the grant via a two-stage tag pipeline.
// Optional macro RAM_ARB_FIXED_PRI_EN: fixed priority (A wins ties) instead
// of round-robin; the round-robin pointer is then not built.
module ram_port_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    output logic                 init_done,
    ram_port_arbiter_if.slave    bus,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    input  logic [DW-1:0]        ram_dout
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {INIT, RUN} state_t;

    state_t        state_reg;
    logic [AW-1:0] cnt_reg;
    logic          init_done_reg;
    logic          ram_we_reg;
    logic [AW-1:0] ram_addr_reg;
    logic [DW-1:0] ram_din_reg;

    // Tag of the command currently on the RAM port, then of the data on ram_dout.
    logic          tag_read_reg;
    logic          tag_id_reg;      // 0 = A, 1 = B
    logic          ret_read_reg;
    logic          ret_id_reg;

    logic          grant_ok;
    logic          a_win;
    logic          gnt_a;
    logic          gnt_b;
    logic          any_gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign grant_ok = (state_reg == RUN) && !clr;

`ifdef RAM_ARB_FIXED_PRI_EN
    assign a_win = bus.a_req;
`else
    // Set when B should win the next tie, i.e. A was granted last.
    logic favor_b_reg;

    assign a_win = bus.a_req && (!bus.b_req || !favor_b_reg);

    // Round-robin pointer: moves only when something is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            favor_b_reg <= 1'b0;
        else if (any_gnt)
            favor_b_reg <= gnt_a;
    end
`endif

    assign gnt_a     = grant_ok && a_win;
    assign gnt_b     = grant_ok && bus.b_req && !a_win;
    assign any_gnt   = gnt_a || gnt_b;
    assign sel_we    = gnt_b ? bus.b_we    : bus.a_we;
    assign sel_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;

    // Control FSM: zero-fill sequencing, init_done and the RAM command register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_din_reg   <= '0;
        end else if (clr) begin
            // Restart the fill; the clr cycle itself issues no write.
            state_reg     <= INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
            ram_we_reg    <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    ram_we_reg   <= 1'b1;
                    ram_addr_reg <= cnt_reg;
                    ram_din_reg  <= '0;
                    cnt_reg      <= cnt_reg + AW'(1);
                    if (cnt_reg == AW'(DEPTH - 1)) begin
                        state_reg     <= RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (any_gnt) begin
                        ram_we_reg   <= sel_we;
                        ram_addr_reg <= sel_addr;
                        ram_din_reg  <= sel_wdata;
                    end else begin
                        // Idle: addr/din hold, the resulting RAM read is ignored.
                        ram_we_reg <= 1'b0;
                    end
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    // Read-return tags: not touched by clr so in-flight reads always complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_read_reg <= 1'b0;
            tag_id_reg   <= 1'b0;
            ret_read_reg <= 1'b0;
            ret_id_reg   <= 1'b0;
        end else begin
            tag_read_reg <= any_gnt && !sel_we;
            tag_id_reg   <= gnt_b;
            ret_read_reg <= tag_read_reg;
            ret_id_reg   <= tag_id_reg;
        end
    end

    assign init_done    = init_done_reg;
    assign ram_we       = ram_we_reg;
    assign ram_addr     = ram_addr_reg;
    assign ram_din      = ram_din_reg;

    assign bus.a_gnt    = gnt_a;
    assign bus.b_gnt    = gnt_b;
    assign bus.a_rvalid = ret_read_reg && !ret_id_reg;
    assign bus.b_rvalid = ret_read_reg &&  ret_id_reg;
    assign bus.a_rdata  = ram_dout;
    assign bus.b_rdata  = ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: a behavioural 16x8 RAM, a cycle model of
// the arbiter's expected grants/commands, and per-port read scoreboards.
module tb_ram_port_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       init_done;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'h00;

    ram_port_arbiter_if #(.AW(4), .DW(8)) bus_if ();

    ram_port_arbiter #(.AW(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .init_done (init_done),
        .bus       (bus_if),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, dout updated only on non-write cycles.
    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'hF0 ^ 8'(i * 7);
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct { logic [7:0] data; int due; } rd_t;
    rd_t q_a[$];
    rd_t q_b[$];

    // Requester intentions (held until granted) and the bench's own model state.
    logic       pa_v = 0, pa_we = 0, pb_v = 0, pb_we = 0;
    logic [3:0] pa_addr = 0, pb_addr = 0;
    logic [7:0] pa_wd = 0, pb_wd = 0;
    logic [7:0] shadow [16];
    int         fill_left = 16;
    logic       exp_done = 0, favor_b = 0, cmd_chk = 0;
    logic       exp_we = 0;
    logic [3:0] exp_addr = 0;
    logic [7:0] exp_din = 0;
    logic       mon_en = 0;

    // Read-return monitor: one line per returned read.
    always @(negedge clk) begin
        if (mon_en) begin
            logic ea, eb;
            rd_t  e;
            ea = (q_a.size() > 0) && (q_a[0].due == cyc);
            eb = (q_b.size() > 0) && (q_b[0].due == cyc);
            check("a_rvalid", bus_if.a_rvalid, ea);
            check("b_rvalid", bus_if.b_rvalid, eb);
            if (ea) begin
                e = q_a.pop_front();
                check("a_rdata", bus_if.a_rdata, e.data);
                $display("cycle %0d: A read data %02h (expected %02h)", cyc, bus_if.a_rdata, e.data);
            end
            if (eb) begin
                e = q_b.pop_front();
                check("b_rdata", bus_if.b_rdata, e.data);
                $display("cycle %0d: B read data %02h (expected %02h)", cyc, bus_if.b_rdata, e.data);
            end
        end
    end

    // Drive this cycle's inputs, check grants, then model the coming edge.
    task automatic step_drive(input logic c);
        logic run, ea, eb, w;
        logic [3:0] ad;
        logic [7:0] wd;
        bus_if.a_req = pa_v; bus_if.a_we = pa_we; bus_if.a_addr = pa_addr; bus_if.a_wdata = pa_wd;
        bus_if.b_req = pb_v; bus_if.b_we = pb_we; bus_if.b_addr = pb_addr; bus_if.b_wdata = pb_wd;
        clr = c;
        #1;
        run = exp_done && !c;
`ifdef RAM_ARB_FIXED_PRI_EN
        ea = run && pa_v;
`else
        ea = run && pa_v && (!pb_v || !favor_b);
`endif
        eb = run && pb_v && !ea;
        check("a_gnt", bus_if.a_gnt, ea);
        check("b_gnt", bus_if.b_gnt, eb);
        cmd_chk = 1;
        if (c) begin
            cmd_chk   = 0;
            fill_left = 16;
        end else if (fill_left > 0) begin
            exp_we   = 1;
            exp_addr = 4'(16 - fill_left);
            exp_din  = 0;
            shadow[exp_addr] = 0;
            fill_left--;
        end else if (ea || eb) begin
            w  = ea ? pa_we : pb_we;
            ad = ea ? pa_addr : pb_addr;
            wd = ea ? pa_wd : pb_wd;
            exp_we = w; exp_addr = ad; exp_din = wd;
            if (w) shadow[ad] = wd;
            else if (ea) q_a.push_back('{shadow[ad], cyc + 2});
            else q_b.push_back('{shadow[ad], cyc + 2});
            favor_b = ea;
            if (ea) pa_v = 0; else pb_v = 0;
        end else begin
            exp_we = 0;
        end
        exp_done = (fill_left == 0);
    endtask

    task automatic step(input logic c);
        @(negedge clk);
        if (cmd_chk) begin
            check("ram_we", ram_we, exp_we);
            check("ram_addr", ram_addr, exp_addr);
            check("ram_din", ram_din, exp_din);
        end
        check("init_done", init_done, exp_done);
        step_drive(c);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while ((pa_v || pb_v) && k < bound) begin step(0); k++; end
        check("grant_timeout", {30'd0, pa_v, pb_v}, 0);
    endtask

    task automatic set_a(input logic we, input logic [3:0] ad, input logic [7:0] wd);
        pa_v = 1; pa_we = we; pa_addr = ad; pa_wd = wd;
    endtask

    task automatic set_b(input logic we, input logic [3:0] ad, input logic [7:0] wd);
        pb_v = 1; pb_we = we; pb_addr = ad; pb_wd = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 0;
        #1;
        check("rst_a_gnt", bus_if.a_gnt, 0);
        check("rst_b_gnt", bus_if.b_gnt, 0);
        check("rst_a_rvalid", bus_if.a_rvalid, 0);
        check("rst_b_rvalid", bus_if.b_rvalid, 0);
        q_a.delete(); q_b.delete();
        pa_v = 0; pb_v = 0; clr = 0;
        bus_if.a_req = 0; bus_if.b_req = 0;
        mon_en = 1;
        @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        @(negedge clk);
        rst_n = 1;
        fill_left = 16; exp_done = 0; favor_b = 0;
        exp_we = 0; exp_addr = 0; exp_din = 0; cmd_chk = 1;
        step_drive(0);
    endtask

    initial begin
        bus_if.a_req = 0; bus_if.a_we = 0; bus_if.a_addr = 0; bus_if.a_wdata = 0;
        bus_if.b_req = 0; bus_if.b_we = 0; bus_if.b_addr = 0; bus_if.b_wdata = 0;
        for (int i = 0; i < 16; i++) shadow[i] = 0;

        // Zero-fill after reset, then read addr 9.
        do_reset();
        set_a(0, 4'd9, 8'h00);
        wait_done(40);
        run_idle(3);

        // A writes 0xA5 to 3, next cycle B reads 3.
        set_a(1, 4'd3, 8'hA5);
        step(0);
        set_b(0, 4'd3, 8'h00);
        wait_done(10);
        run_idle(3);

        // Give addresses distinct contents, then continuous reads on both ports.
        for (int i = 0; i < 16; i++) begin
            set_a(1, 4'(i), 8'(8'h30 + i * 5));
            wait_done(10);
        end
        for (int i = 0; i < 10; i++) begin
            if (!pa_v) set_a(0, 4'(i), 8'h00);
            if (!pb_v) set_b(0, 4'(15 - i), 8'h00);
            step(0);
        end
        wait_done(30);
        run_idle(3);

        // B read of 7 in flight across clr; then A read of 7 waits out the fill.
        set_a(1, 4'd7, 8'h77);
        wait_done(10);
        set_b(0, 4'd7, 8'h00);
        wait_done(10);
        set_a(0, 4'd7, 8'h00);
        step(1);
        wait_done(40);
        run_idle(3);

        // Random mix with occasional clr.
        for (int i = 0; i < 120; i++) begin
            if (!pa_v && $urandom_range(0, 1) == 1) set_a(1'($urandom), 4'($urandom), 8'($urandom));
            if (!pb_v && $urandom_range(0, 1) == 1) set_b(1'($urandom), 4'($urandom), 8'($urandom));
            step(1'($urandom_range(0, 39) == 0));
        end
        wait_done(60);
        run_idle(3);

        // Reset while reads are in flight.
        set_a(0, 4'd1, 8'h00);
        set_b(0, 4'd2, 8'h00);
        step(0);
        step(0);
        do_reset();
        run_idle(20);
        set_b(0, 4'd2, 8'h00);
        wait_done(10);
        run_idle(4);

        check("a_queue_left", q_a.size(), 0);
        check("b_queue_left", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
